// File: rtl/scr1_axi_mem_slave_highspeed.sv
// AXI4 burst slave in front of a single-port synchronous SRAM.
// One burst in flight; reads stream at one beat per cycle when the master does not stall.
module scr1_axi_mem_slave_highspeed #(
  parameter int SCR1_AXI_IDWIDTH = 4,
  parameter int SCR1_ADDR_WIDTH  = 32,
  parameter int SCR1_DATA_WIDTH  = 128,
  parameter int SCR1_MEM_BYTES   = 4096,
  localparam int NB = SCR1_DATA_WIDTH / 8,
  localparam int MW = $clog2(SCR1_MEM_BYTES / NB)
) (
  input  logic                        clk,
  input  logic                        rst,
  // write address
  input  logic [SCR1_AXI_IDWIDTH-1:0] awid,
  input  logic [SCR1_ADDR_WIDTH-1:0]  awaddr,
  input  logic [7:0]                  awlen,
  input  logic [2:0]                  awsize,
  input  logic [1:0]                  awburst,
  input  logic                        awvalid,
  output logic                        awready,
  // write data
  input  logic [SCR1_DATA_WIDTH-1:0]  wdata,
  input  logic [NB-1:0]               wstrb,
  input  logic                        wlast,
  input  logic                        wvalid,
  output logic                        wready,
  // write response
  output logic [SCR1_AXI_IDWIDTH-1:0] bid,
  output logic [1:0]                  bresp,
  output logic                        bvalid,
  input  logic                        bready,
  // read address
  input  logic [SCR1_AXI_IDWIDTH-1:0] arid,
  input  logic [SCR1_ADDR_WIDTH-1:0]  araddr,
  input  logic [7:0]                  arlen,
  input  logic [2:0]                  arsize,
  input  logic [1:0]                  arburst,
  input  logic                        arvalid,
  output logic                        arready,
  // read data
  output logic [SCR1_AXI_IDWIDTH-1:0] rid,
  output logic [SCR1_DATA_WIDTH-1:0]  rdata,
  output logic [1:0]                  rresp,
  output logic                        rlast,
  output logic                        rvalid,
  input  logic                        rready,
  // SRAM
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [MW-1:0]               mem_addr,
  output logic [SCR1_DATA_WIDTH-1:0]  mem_wdata,
  output logic [NB-1:0]               mem_wstrb,
  input  logic [SCR1_DATA_WIDTH-1:0]  mem_rdata,
  output logic                        slv_idle
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] WB   = 2'd3;

  localparam int LNB = $clog2(NB);
  localparam int EW  = SCR1_ADDR_WIDTH + 9;
  localparam logic [2:0]    MAX_SIZE = 3'(LNB);
  localparam logic [EW-1:0] MEM_LIM  = EW'(SCR1_MEM_BYTES);

  logic [1:0]                  state;
  logic                        prio;      // 0: read wins contention, 1: write wins
  logic [SCR1_AXI_IDWIDTH-1:0] id_q;
  logic [SCR1_ADDR_WIDTH-1:0]  addr_q;
  logic [2:0]                  size_q;
  logic [1:0]                  burst_q;
  logic [7:0]                  len_q;
  logic                        err_q;
  logic                        rd_start;
  logic                        rvalid_q;
  logic [7:0]                  rcnt;

  logic                        idle, gnt_r, gnt_w, wr_beat, rd_issue, rlast_int, rd_hs;
  logic [SCR1_AXI_IDWIDTH-1:0] ax_id;
  logic [SCR1_ADDR_WIDTH-1:0]  ax_addr, step, addr_nxt;
  logic [7:0]                  ax_len;
  logic [2:0]                  ax_size;
  logic [1:0]                  ax_burst;
  logic [EW-1:0]               ax_bytes, ax_end;
  logic                        ax_err;

  assign idle  = (state == IDLE);
  assign gnt_r = idle & ~rst & arvalid & (~awvalid | ~prio);
  assign gnt_w = idle & ~rst & awvalid & (~arvalid | prio);

  assign ax_id    = gnt_r ? arid    : awid;
  assign ax_addr  = gnt_r ? araddr  : awaddr;
  assign ax_len   = gnt_r ? arlen   : awlen;
  assign ax_size  = gnt_r ? arsize  : awsize;
  assign ax_burst = gnt_r ? arburst : awburst;

  // End-of-burst bound is computed wide enough that it cannot wrap.
  assign ax_bytes = EW'({1'b0, ax_len} + 9'd1) << ax_size;
  assign ax_end   = EW'(ax_addr) + ax_bytes;
  assign ax_err   = ax_burst[1] | (ax_size > MAX_SIZE) | (ax_end > MEM_LIM);

  assign step     = {{(SCR1_ADDR_WIDTH-1){1'b0}}, 1'b1} << size_q;
  assign addr_nxt = (burst_q == 2'b00) ? addr_q : ((addr_q & ~(step - 1'b1)) + step);

  assign wr_beat   = (state == WR) & wvalid;
  assign rlast_int = (rcnt == len_q);
  assign rd_hs     = rvalid_q & rready;
  // Next read goes out as the current beat is taken, so the SRAM output stays valid while stalled.
  assign rd_issue  = (state == RD) & (rd_start | (rd_hs & ~rlast_int));

  assign arready   = gnt_r;
  assign awready   = gnt_w;
  assign wready    = (state == WR);

  assign mem_req   = ~err_q & (wr_beat | rd_issue);
  assign mem_we    = ~err_q & wr_beat;
  assign mem_addr  = addr_q[LNB +: MW];
  assign mem_wdata = wdata;
  assign mem_wstrb = wr_beat ? wstrb : '0;

  assign bvalid    = (state == WB);
  assign bid       = id_q;
  assign bresp     = (bvalid & err_q) ? 2'b10 : 2'b00;

  assign rvalid    = rvalid_q;
  assign rid       = id_q;
  assign rdata     = (rvalid_q & ~err_q) ? mem_rdata : '0;
  assign rresp     = (rvalid_q & err_q) ? 2'b10 : 2'b00;
  assign rlast     = rvalid_q & rlast_int;

  assign slv_idle  = idle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      prio     <= 1'b0;
      id_q     <= '0;
      addr_q   <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      len_q    <= '0;
      err_q    <= 1'b0;
      rd_start <= 1'b0;
      rvalid_q <= 1'b0;
      rcnt     <= '0;
    end else begin
      rd_start <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_r | gnt_w) begin
            state    <= gnt_r ? RD : WR;
            id_q     <= ax_id;
            addr_q   <= ax_addr;
            size_q   <= ax_size;
            burst_q  <= ax_burst;
            len_q    <= ax_len;
            err_q    <= ax_err;
            rd_start <= gnt_r;
            rcnt     <= '0;
            if (arvalid & awvalid) prio <= gnt_r;
          end
        end
        WR: begin
          if (wr_beat) begin
            addr_q <= addr_nxt;
            if (wlast) state <= WB;
          end
        end
        WB: begin
          if (bready) state <= IDLE;
        end
        RD: begin
          if (rd_issue) begin
            rvalid_q <= 1'b1;
            addr_q   <= addr_nxt;
          end else if (rd_hs) begin
            rvalid_q <= 1'b0;
          end
          if (rd_hs) begin
            rcnt <= rcnt + 8'd1;
            if (rlast_int) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scr1_axi_mem_slave_highspeed.sv
// Scoreboard bench: drivers push expected R/B responses from a byte-level memory model,
// a negedge monitor pops and compares whenever the DUT hands over a beat.
module tb_scr1_axi_mem_slave_highspeed;
  localparam int IDW = 4, AW = 32, DW = 128, NB = 16, MB = 4096, MW = 8, NW = MB / NB;

  logic clk = 1'b0, rst;
  logic [IDW-1:0] awid, arid, bid, rid;
  logic [AW-1:0]  awaddr, araddr;
  logic [7:0]     awlen, arlen;
  logic [2:0]     awsize, arsize;
  logic [1:0]     awburst, arburst, bresp, rresp;
  logic           awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic           arvalid, arready, rlast, rvalid, rready;
  logic [DW-1:0]  wdata, rdata, mem_wdata, mem_rdata;
  logic [NB-1:0]  wstrb, mem_wstrb;
  logic           mem_req, mem_we, slv_idle;
  logic [MW-1:0]  mem_addr;

  always #5 clk = ~clk;

  scr1_axi_mem_slave_highspeed dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .slv_idle(slv_idle)
  );

  // SRAM behind the DUT: read data registered, held until the next request.
  logic [DW-1:0] sram [NW];
  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < NB; b++) if (mem_wstrb[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [1:0]     resp;
    logic           last;
    logic [DW-1:0]  data;
  } r_exp_t;

  logic [7:0]        ref_mem [MB];
  r_exp_t            rq[$];
  logic [IDW+1:0]    bq[$];
  int                glog[$];
  int n_chk = 0, n_fail = 0, cyc = 0, n_rd = 0, n_wr = 0, rbeats = 0;
  int ar_cyc, wl_cyc;
  bit ar_pend = 0, b_pend = 0, stall_prev = 0;
  logic [IDW+DW+3:0] stall_val;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  task automatic chk_rst_outs();
    chk("rst_ctrl", {arready, awready, wready, bvalid, rvalid, mem_req, mem_we, slv_idle}, 8'b0000_0001);
    chk("rst_resp", {bid, rid, bresp, rresp, rlast}, '0);
    chk("rst_rdata", rdata, '0);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    r_exp_t e;
    if (rst) begin
      ar_pend = 0; b_pend = 0; stall_prev = 0;
    end else begin
      if (mem_req && !mem_we) n_rd++;
      if (mem_req && mem_we) n_wr++;
      if (arvalid && arready) begin glog.push_back(0); ar_cyc = cyc; ar_pend = 1; end
      if (awvalid && awready) glog.push_back(1);
      if (rvalid && ar_pend) begin chk("rd_first_latency", cyc, ar_cyc + 2); ar_pend = 0; end
      if (wvalid && wready && wlast) begin wl_cyc = cyc; b_pend = 1; end
      if (bvalid && b_pend) begin chk("b_latency", cyc, wl_cyc + 1); b_pend = 0; end
      if (stall_prev) chk("r_stall_stable", {rvalid, rid, rresp, rlast, rdata}, stall_val);
      if (rvalid && !rready) chk("r_stall_no_mem", mem_req, 0);
      stall_prev = rvalid && !rready;
      stall_val  = {rvalid, rid, rresp, rlast, rdata};
      if (rvalid && rready) begin
        if (rq.size() == 0) chk("r_unexpected", {rid, rresp, rlast}, '1 );
        else begin
          e = rq.pop_front();
          chk("r_beat", {rid, rresp, rlast, rdata}, {e.id, e.resp, e.last, e.data});
        end
        rbeats++;
      end
      if (bvalid && bready) begin
        if (bq.size() == 0) chk("b_unexpected", {bid, bresp}, '1);
        else chk("b_resp", {bid, bresp}, bq.pop_front());
      end
    end
  end

  function automatic bit burst_err(input logic [AW-1:0] addr, input int len, input int size, input int burst);
    return (burst >= 2) || ((1 << size) > NB) || (longint'(addr) + (longint'(len + 1) << size) > MB);
  endfunction

  function automatic longint next_addr(input longint a, input int size, input int burst);
    if (burst == 1) return (a / (1 << size)) * (1 << size) + (1 << size);
    return a;
  endfunction

  // mode: 0 rready always 1, 1 pattern 1,0,0 repeating, 2 random. abort_at >= 0: reset after that many beats.
  task automatic do_read(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input int len, input int size,
                         input int burst, input int mode, input int abort_at);
    bit err; longint a; int rd0, b0, k, to; r_exp_t e;
    err = burst_err(addr, len, size, burst);
    a = addr;
    for (int i = 0; i <= len; i++) begin
      e.id = id; e.resp = err ? 2'b10 : 2'b00; e.last = (i == len); e.data = '0;
      if (!err) for (int b = 0; b < NB; b++) e.data[b*8 +: 8] = ref_mem[(a / NB) * NB + b];
      rq.push_back(e);
      a = next_addr(a, size, burst);
    end
    rd0 = n_rd; b0 = rbeats;
    arid = id; araddr = addr; arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst); arvalid = 1'b1;
    rready = (mode == 0);
    to = 0;
    do begin @(negedge clk); to++; end while (!arready && to < 200);
    if (!arready) begin bound_fail("ar_handshake"); arvalid = 1'b0; rq.delete(); return; end
    @(posedge clk); #1 arvalid = 1'b0;
    k = 0; to = 0;
    while (rbeats - b0 < len + 1 && to < 3000) begin
      if (abort_at >= 0 && rbeats - b0 == abort_at) begin
        rst = 1'b1; #2;
        chk_rst_outs();
        rq.delete();
        @(posedge clk); #1 rst = 1'b0;
        rd0 = n_rd;
        repeat (4) @(posedge clk);
        #1 chk("abort_no_mem", n_rd - rd0, 0);
        chk("abort_idle", {slv_idle, rvalid}, 2'b10);
        rready = 1'b1;
        return;
      end
      case (mode)
        0:       rready = 1'b1;
        1:       rready = (k % 3 == 0);
        default: rready = 1'($urandom_range(0, 1));
      endcase
      k++; to++;
      @(posedge clk); #1;
    end
    if (rbeats - b0 < len + 1) begin bound_fail("r_burst"); rq.delete(); end
    else chk("rd_mem_reads", n_rd - rd0, err ? 0 : len + 1);
    rready = 1'b1;
  endtask

  task automatic do_write(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input int len, input int size,
                          input int burst, input logic [NB-1:0] s0, input logic [NB-1:0] s1);
    bit err; longint a; int wr0, to; logic [DW-1:0] d[$]; logic [NB-1:0] s[$];
    logic [DW-1:0] dd; logic [NB-1:0] ss;
    err = burst_err(addr, len, size, burst);
    a = addr;
    for (int i = 0; i <= len; i++) begin
      dd = {$urandom(), $urandom(), $urandom(), $urandom()};
      ss = (i == 0) ? s0 : (i == 1) ? s1 : NB'($urandom());
      d.push_back(dd); s.push_back(ss);
      if (!err) for (int b = 0; b < NB; b++) if (ss[b]) ref_mem[(a / NB) * NB + b] = dd[b*8 +: 8];
      a = next_addr(a, size, burst);
    end
    bq.push_back({id, err ? 2'b10 : 2'b00});
    wr0 = n_wr;
    awid = id; awaddr = addr; awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst); awvalid = 1'b1;
    to = 0;
    do begin @(negedge clk); to++; end while (!awready && to < 200);
    if (!awready) begin bound_fail("aw_handshake"); awvalid = 1'b0; bq.delete(); return; end
    @(posedge clk); #1 awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      wdata = d[i]; wstrb = s[i]; wlast = (i == len); wvalid = 1'b1;
      to = 0;
      do begin @(negedge clk); to++; end while (!wready && to < 50);
      if (!wready) begin bound_fail("w_beat"); break; end
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    to = 0;
    while (bq.size() != 0 && to < 50) begin @(posedge clk); #1; to++; end
    if (bq.size() != 0) begin bound_fail("b_wait"); bq.delete(); end
    else chk("wr_mem_writes", n_wr - wr0, err ? 0 : len + 1);
  endtask

  initial begin
    logic [DW-1:0] w;
    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < NW; i++) begin
      w = {$urandom(), $urandom(), $urandom(), $urandom()};
      sram[i] = w;
      for (int b = 0; b < NB; b++) ref_mem[i * NB + b] = w[b*8 +: 8];
    end
    repeat (3) @(posedge clk);
    #1 chk_rst_outs();
    rst = 1'b0; bready = 1'b1; rready = 1'b1;
    @(posedge clk); #1;

    do_read(4'd3, 32'h40, 3, 4, 1, 0, -1);
    do_write(4'd5, 32'h100, 1, 4, 1, 16'hFFFF, 16'h000F);
    do_read(4'd1, 32'h100, 1, 4, 1, 0, -1);
    do_read(4'd2, 32'h200, 7, 4, 1, 1, -1);

    // contention: grant order alternates starting with read
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    for (int r = 0; r < 4; r++) begin
      glog.delete();
      fork
        do_read(4'(r), 32'(r * 16), 0, 4, 1, 0, -1);
        do_write(4'(8 + r), 32'(32'h800 + r * 16), 0, 4, 1, '1, '1);
      join
      if (glog.size() < 2) bound_fail("grant_log");
      else chk("grant_order", {glog[0][0], glog[1][0]}, (r % 2 == 0) ? 2'b01 : 2'b10);
    end

    do_read(4'd6, 32'hFF0, 1, 4, 1, 0, -1);
    do_read(4'd7, 32'h80, 1, 4, 2, 0, -1);
    do_write(4'd9, 32'hFFF8, 0, 4, 1, '1, '1);

    do_read(4'd10, 32'h300, 3, 4, 1, 0, 2);
    do_read(4'd11, 32'h300, 3, 4, 1, 0, -1);

    for (int i = 0; i < 30; i++) begin
      int sz, ln, bu; logic [AW-1:0] ad;
      sz = (($urandom_range(0, 9) == 0) ? 5 : $urandom_range(0, 4));
      ln = $urandom_range(0, 7);
      bu = (($urandom_range(0, 9) == 0) ? 2 : $urandom_range(0, 1));
      ad = 32'($urandom_range(0, MB - 1));
      if ($urandom_range(0, 1) == 1) do_write(4'($urandom()), ad, ln, sz, bu, NB'($urandom()), NB'($urandom()));
      else do_read(4'($urandom()), ad, ln, sz, bu, 2, -1);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
